dm_access_ctrl: RTL and testbench

//  Sequences the data-memory address register (MAR) and data-memory strobes on behalf of two

---
 rtl/dm_access_ctrl_if.sv | 40 ++++
 rtl/dm_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_if.sv
// Bundle of requester-side and memory-side signals of the data-memory access controller.
// The "slave" modport is the controller; the "master" modport is everything around it
// (the two requesters, the MAR and the data memory).
interface dm_access_ctrl_if #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
);
  // requester side
  logic [1:0]           req_valid;
  logic [1:0]           req_we;
  logic [2*ADDR_W-1:0]  req_addr;
  logic [2*BURST_W-1:0] req_len;
  logic [2*DATA_W-1:0]  req_wdata;
  logic [1:0]           gnt;
  logic [1:0]           beat;
  logic [1:0]           done;
  logic [DATA_W-1:0]    rdata;
  logic                 busy;
  // MAR / data-memory side
  logic                 mar_load;
  logic [31:0]          mar_value;
  logic                 mar_inc;
  logic                 dm_r;
  logic                 dm_wr;
  logic [DATA_W-1:0]    dm_wdata;
  logic [DATA_W-1:0]    dm_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, dm_rdata,
    input  gnt, beat, done, rdata, busy,
    input  mar_load, mar_value, mar_inc, dm_r, dm_wr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, dm_rdata,
    output gnt, beat, done, rdata, busy,
    output mar_load, mar_value, mar_inc, dm_r, dm_wr, dm_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: round-robin arbitration between the core (req 0) and the
// downsample engine (req 1), MAR load/increment sequencing and per-word dm_r/dm_wr strobes.
//
// Handshake: a requester raises req_valid[i] with we/addr/len stable and keeps it high until
// gnt[i] is seen; the request is only sampled while the controller is IDLE. Each word is then
// acknowledged by a one-cycle beat[i] (write word consumed from req_wdata / rdata valid), and
// the final beat carries done[i]. There is no back-pressure once a burst has been granted.
module dm_access_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4,
  parameter int MEM_LAT = 2
) (
  input  logic            clock,
  input  logic            rst,
  dm_access_ctrl_if.slave bus,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4
  } state_t;

  // wait_cnt runs MEM_LAT-1 .. 0 across the WAIT cycles; 0 marks the final one
  localparam int                WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT - 1);

  state_t              state;
  state_t              state_nxt;

  // transaction context, latched at grant
  logic                own;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  cnt_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rr_ptr;
  logic [DATA_W-1:0]   rdata_q;

  // arbitration results
  logic                grant_any;
  logic                grant_id;
  logic                grant_we;
  logic [ADDR_W-1:0]   grant_addr;
  logic [BURST_W-1:0]  grant_len;

  // per-cycle decode
  logic                last_word;
  logic                wait_final;
  logic                beat_now;
  logic                done_now;
  logic                rdata_cap;
  logic                busy_now;
  logic [1:0]          owner_hot;
  logic [DATA_W-1:0]   owner_wdata;

  assign last_word  = (cnt_q == '0);
  assign wait_final = (state == S_WAIT) && (wait_cnt == '0);
  assign beat_now   = ((state == S_ACCESS) && we_q) || wait_final;
  assign done_now   = beat_now && last_word;
  assign busy_now   = (state != S_IDLE);
  assign owner_hot  = own ? 2'b10 : 2'b01;
  assign dbg_state  = state;

  // dm_rdata is sampled on the MEM_LAT-th rising edge after dm_r goes high, which is the edge
  // that opens the final WAIT cycle, so rdata is already valid while beat is high.
  assign rdata_cap  = (MEM_LAT == 1) ? ((state == S_ACCESS) && !we_q)
                                     : ((state == S_WAIT) && (wait_cnt == WAIT_W'(1)));

  // Round-robin choice among pending requests and selection of the winner's request fields
  always_comb begin
    grant_any  = (state == S_IDLE) && (bus.req_valid != 2'b00);
    grant_id   = (bus.req_valid == 2'b11) ? rr_ptr : bus.req_valid[1];
    grant_we   = grant_id ? bus.req_we[1] : bus.req_we[0];
    grant_addr = grant_id ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    grant_len  = grant_id ? bus.req_len[2*BURST_W-1:BURST_W] : bus.req_len[BURST_W-1:0];
  end

  // Live write word of the current owner
  always_comb begin
    owner_wdata = own ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  end

  // State register
  always_ff @(posedge clock) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (we_q) begin
          state_nxt = last_word ? S_IDLE : S_NEXT;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_final) begin
          state_nxt = last_word ? S_IDLE : S_NEXT;
        end
      end
      S_NEXT: begin
        state_nxt = S_ACCESS;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state and the latched transaction context
  always_comb begin
    bus.busy      = busy_now;
    bus.gnt       = busy_now ? owner_hot : 2'b00;
    bus.beat      = beat_now ? owner_hot : 2'b00;
    bus.done      = done_now ? owner_hot : 2'b00;
    bus.rdata     = rdata_q;
    bus.mar_load  = (state == S_LOAD);
    bus.mar_value = (state == S_LOAD) ? {{(32-ADDR_W){1'b0}}, addr_q} : 32'd0;
    bus.mar_inc   = (state == S_NEXT);
    bus.dm_r      = (state == S_ACCESS) && !we_q;
    bus.dm_wr     = (state == S_ACCESS) && we_q;
    bus.dm_wdata  = ((state == S_ACCESS) && we_q) ? owner_wdata : '0;
  end

  // Transaction context, word/latency counters, read data and round-robin pointer
  always_ff @(posedge clock) begin
    if (!rst) begin
      own      <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      wait_cnt <= '0;
      rr_ptr   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (grant_any) begin
        own    <= grant_id;
        we_q   <= grant_we;
        addr_q <= grant_addr;
        cnt_q  <= grant_len;
      end else if (state == S_NEXT) begin
        cnt_q  <= cnt_q - BURST_W'(1);
      end
      if (state == S_ACCESS) begin
        wait_cnt <= WAIT_INIT;
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (rdata_cap) begin
        rdata_q <= bus.dm_rdata;
      end
      // the requester that just finished loses the next tie
      if (done_now) begin
        rr_ptr <= ~own;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: models the MAR and a MEM_LAT=2 data memory around
// the controller, issues directed and random bursts, and compares every beat against a
// reference built from the transaction-level rules (addresses, data, beat offsets, owner).
module tb_dm_access_ctrl;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 2;
  localparam int EW  = 43; // {id, we, last, offset[7:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] dbg_state;
  dm_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus ();

  dm_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MEM_LAT(LAT)) dut (
    .clock(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int grant_cyc = 0;
  int rr_model  = 0;

  logic [EW-1:0] exp_q[$];
  logic [20:0]   exp_ld_q[$];
  logic [EW-1:0] mon_e;
  logic [20:0]   mon_l;
  logic          prev_done = 1'b0;
  logic [1:0]    prev_gnt  = 2'b00;

  logic [31:0] mem     [bit [19:0]];
  logic [31:0] ref_mem [bit [19:0]];
  logic [19:0] mar = '0;
  logic [31:0] wbuf [2][16];
  int          widx [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got an output event, expected none pending (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] init_val(input logic [19:0] a);
    return {a[11:0], a} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [1:0] hot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // ---------------- MAR and data memory around the controller ----------------
  always @(negedge clk) begin
    if (bus.mar_load) mar <= bus.mar_value[19:0];
    else if (bus.mar_inc) mar <= mar + 20'd1;
  end

  always @(posedge clk) begin
    if (bus.dm_wr) mem[mar] = bus.dm_wdata;
    bus.dm_rdata <= bus.dm_r ? mem_rd(mar) : $urandom;
  end

  // requesters present the next write word after each consumed beat
  always @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (!rst) widx[r] <= 0;
      else if (bus.done[r]) widx[r] <= 0;
      else if (bus.beat[r]) widx[r] <= widx[r] + 1;
    end
  end

  always_comb begin
    bus.req_wdata = {wbuf[1][widx[1] & 15], wbuf[0][widx[0] & 15]};
  end

  // ---------------- reference model ----------------
  // One burst = len+1 words at consecutive (wrapping) addresses; first beat 2 cycles after
  // grant for writes, 2+LAT for reads; then every 2 (write) or LAT+2 (read) cycles.
  task automatic push_txn(input int r, input bit we, input logic [19:0] a, input int len);
    logic [19:0] wa;
    logic [31:0] d;
    int off;
    exp_ld_q.push_back({r[0], a});
    for (int i = 0; i <= len; i++) begin
      wa  = a + 20'(i);
      off = we ? (2 + 2 * i) : (2 + LAT + (LAT + 2) * i);
      if (we) begin
        d = wbuf[r][i];
        ref_mem[wa] = d;
      end else begin
        d = ref_rd(wa);
      end
      exp_q.push_back({r[0], we, (i == len), off[7:0], d});
    end
    rr_model = (r == 0) ? 1 : 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    chk("rd_wr_exclusive", 64'(bus.dm_r & bus.dm_wr), 64'd0);
    chk("load_inc_exclusive", 64'(bus.mar_load & bus.mar_inc), 64'd0);
    chk("gnt_onehot", 64'($countones(bus.gnt) <= 1), 64'd1);
    chk("busy_vs_gnt", 64'(bus.busy), 64'(|bus.gnt));
    if (prev_done) chk("busy_after_done", 64'(bus.busy), 64'd0);
    if (bus.gnt != 2'b00 && prev_gnt == 2'b00) grant_cyc = cyc - 1;
    if (bus.mar_load) begin
      if (exp_ld_q.size() == 0) note_fail("unexpected_mar_load");
      else begin
        mon_l = exp_ld_q.pop_front();
        chk("mar_value", 64'(bus.mar_value), 64'({12'd0, mon_l[19:0]}));
        chk("load_owner", 64'(bus.gnt), 64'(hot(mon_l[20])));
        chk("load_cycle", 64'(cyc - grant_cyc), 64'd1);
      end
    end
    if (bus.beat != 2'b00) begin
      if (exp_q.size() == 0) note_fail("unexpected_beat");
      else begin
        mon_e = exp_q.pop_front();
        chk("beat_owner", 64'(bus.beat), 64'(hot(mon_e[42])));
        chk("done_flag", 64'(bus.done), 64'(mon_e[40] ? hot(mon_e[42]) : 2'b00));
        chk("beat_cycle", 64'(cyc - grant_cyc), 64'(mon_e[39:32]));
        if (mon_e[41]) begin
          chk("dm_wr_at_beat", 64'(bus.dm_wr), 64'd1);
          chk("dm_wdata", 64'(bus.dm_wdata), 64'(mon_e[31:0]));
        end else begin
          chk("rdata", 64'(bus.rdata), 64'(mon_e[31:0]));
        end
      end
    end else begin
      chk("done_without_beat", 64'(bus.done), 64'd0);
    end
    prev_done <= |bus.done;
    prev_gnt  <= bus.gnt;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input int r);
    int n = 0;
    while (!bus.gnt[r] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gnt_seen", 64'(bus.gnt[r]), 64'd1);
  endtask

  task automatic wait_done(input int r);
    int n = 0;
    while (!bus.done[r] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(bus.done[r]), 64'd1);
  endtask

  task automatic check_mem(input logic [19:0] a, input int len);
    for (int i = 0; i <= len; i++)
      chk("mem_word", 64'(mem_rd(a + 20'(i))), 64'(ref_rd(a + 20'(i))));
  endtask

  task automatic chk_idle();
    chk("idle_gnt", 64'(bus.gnt), 64'd0);
    chk("idle_beat", 64'(bus.beat), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("idle_rdata", 64'(bus.rdata), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_mar_load", 64'(bus.mar_load), 64'd0);
    chk("idle_mar_value", 64'(bus.mar_value), 64'd0);
    chk("idle_mar_inc", 64'(bus.mar_inc), 64'd0);
    chk("idle_dm_r", 64'(bus.dm_r), 64'd0);
    chk("idle_dm_wr", 64'(bus.dm_wr), 64'd0);
    chk("idle_dm_wdata", 64'(bus.dm_wdata), 64'd0);
    chk("idle_state", 64'(dbg_state), 64'd0);
  endtask

  task automatic fill_wbuf();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) wbuf[r][i] = $urandom;
  endtask

  task automatic set_req(input int r, input bit we, input logic [19:0] a, input int len);
    bus.req_we[r] = we;
    bus.req_addr[r*AW +: AW] = a;
    bus.req_len[r*BW +: BW] = 4'(len);
  endtask

  task automatic do_txn(input int r, input bit we, input logic [19:0] a, input int len,
                        input bit scramble);
    set_req(r, we, a, len);
    push_txn(r, we, a, len);
    bus.req_valid[r] = 1'b1;
    wait_gnt(r);
    bus.req_valid[r] = 1'b0;
    if (scramble) set_req(r, ~we, 20'($urandom), $urandom_range(0, 15));
    wait_done(r);
    @(posedge clk); #1;
    if (we) check_mem(a, len);
  endtask

  task automatic do_pair(input bit we0, input logic [19:0] a0, input int l0,
                         input bit we1, input logic [19:0] a1, input int l1);
    bit          wes [2];
    logic [19:0] as  [2];
    int          ls  [2];
    int          first;
    int          second;
    wes[0] = we0; as[0] = a0; ls[0] = l0;
    wes[1] = we1; as[1] = a1; ls[1] = l1;
    set_req(0, we0, a0, l0);
    set_req(1, we1, a1, l1);
    first  = rr_model;
    second = 1 - first;
    push_txn(first, wes[first], as[first], ls[first]);
    push_txn(second, wes[second], as[second], ls[second]);
    bus.req_valid = 2'b11;
    wait_gnt(first);
    bus.req_valid[first] = 1'b0;
    wait_gnt(second);
    bus.req_valid[second] = 1'b0;
    wait_done(second);
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) if (wes[r]) check_mem(as[r], ls[r]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    fill_wbuf();
    repeat (3) @(posedge clk);
    #1;
    chk_idle();
    rst = 1'b1;

    // both requesters tie twice: req0, req1, then req0, req1
    fill_wbuf();
    do_pair(1'b0, 20'h00200, 1, 1'b1, 20'h00300, 2);
    fill_wbuf();
    do_pair(1'b1, 20'h00400, 0, 1'b0, 20'h00300, 2);

    // single read at 0x10
    do_txn(0, 1'b0, 20'h00010, 0, 1'b0);

    // four-word write burst from req1
    wbuf[1][0] = 32'hA; wbuf[1][1] = 32'hB; wbuf[1][2] = 32'hC; wbuf[1][3] = 32'hD;
    do_txn(1, 1'b1, 20'h00100, 3, 1'b0);
    chk("burst_word_last", 64'(mem_rd(20'h00103)), 64'hD);

    // read across the top of the address space
    wbuf[1][0] = 32'h1234_5678;
    do_txn(1, 1'b1, 20'h00000, 0, 1'b0);
    do_txn(0, 1'b0, 20'hFFFFF, 1, 1'b0);

    // reset in the middle of an 8-word read burst
    set_req(0, 1'b0, 20'h00800, 7);
    push_txn(0, 1'b0, 20'h00800, 7);
    bus.req_valid[0] = 1'b1;
    wait_gnt(0);
    bus.req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_ld_q.delete();
    rr_model = 0;
    chk_idle();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_txn(0, 1'b0, 20'h00810, 2, 1'b0);

    // request fields change after grant
    fill_wbuf();
    do_txn(0, 1'b1, 20'h00A00, 2, 1'b1);
    do_txn(0, 1'b0, 20'h00A00, 2, 1'b1);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      logic [19:0] ra0;
      logic [19:0] ra1;
      fill_wbuf();
      ra0 = ($urandom_range(0, 3) == 0) ? (20'hFFFF0 + 20'($urandom_range(0, 15))) : 20'($urandom);
      ra1 = 20'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0)
        do_pair(1'($urandom), ra0, $urandom_range(0, 15), 1'($urandom), ra1, $urandom_range(0, 15));
      else
        do_txn($urandom_range(0, 1), 1'($urandom), ra0, $urandom_range(0, 15), 1'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
    chk("loads_outstanding", 64'(exp_ld_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
